// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Antares-R2 instruction fetch stage: PC / request address, req-ack fetch
// protocol, IF/ID instruction register and a one-entry skid buffer that
// absorbs a word returned while decode is stalled.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master imem,
  input  logic         stall,
  input  logic         jump,
  input  logic         beq,
  input  logic         bne,
  input  logic         zero,
  output logic [31:0]  instr,
  output logic [5:0]   opcode,
  output logic [31:0]  pc_plus4,
  output logic         instr_valid
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] req_addr_reg;      // address currently presented to imem
  logic [31:0] redirect_addr_reg; // target parked while a request is outstanding
  logic [31:0] skid_reg;
  logic [31:0] skid_pc4_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc4_reg;
  logic        valid_reg;

  logic        consume;
  logic        taken;
  logic        id_free;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] target;
  logic [31:0] addr_plus4;

  // The instruction in IF/ID is resolved the cycle decode accepts it.
  assign consume       = valid_reg & ~stall;
  assign taken         = consume & (jump | (beq & zero) | (bne & ~zero));
  assign id_free       = ~valid_reg | ~stall;
  assign branch_target = pc4_reg + {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
  assign jump_target   = {pc4_reg[31:28], instr_reg[25:0], 2'b00};
  assign target        = jump ? jump_target : branch_target;
  assign addr_plus4    = req_addr_reg + 32'd4;

  assign instr       = instr_reg;
  assign opcode      = instr_reg[31:26];
  assign pc_plus4    = pc4_reg;
  assign instr_valid = valid_reg;
  assign imem.imem_addr = req_addr_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_REQ;
    else       state_reg <= state_next;
  end

  // Next-state: park in S_WAIT while the skid holds a word, S_DROP while a
  // wrong-path request must still be acknowledged.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_REQ: begin
        if (imem.imem_ack) begin
          if (!taken && !id_free) state_next = S_WAIT;
        end else if (taken) begin
          state_next = S_DROP;
        end
      end
      S_WAIT:  if (taken || !stall) state_next = S_REQ;
      S_DROP:  if (imem.imem_ack) state_next = S_REQ;
      default: state_next = S_REQ;
    endcase
  end

  // Outputs: no request while the skid is full or during reset.
  always_comb begin
    imem.imem_req = 1'b0;
    if (!reset) imem.imem_req = (state_reg == S_REQ) || (state_reg == S_DROP);
  end

  // Datapath: request address, IF/ID register, skid buffer and redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr_reg      <= RESET_PC;
      redirect_addr_reg <= RESET_PC;
      skid_reg          <= 32'd0;
      skid_pc4_reg      <= 32'd0;
      instr_reg         <= 32'd0;
      pc4_reg           <= 32'd0;
      valid_reg         <= 1'b0;
    end else begin
      case (state_reg)
        S_REQ: begin
          if (imem.imem_ack) begin
            if (taken) begin
              req_addr_reg <= target;
              valid_reg    <= 1'b0;
            end else if (id_free) begin
              instr_reg    <= imem.imem_rdata;
              pc4_reg      <= addr_plus4;
              valid_reg    <= 1'b1;
              req_addr_reg <= addr_plus4;
            end else begin
              skid_reg     <= imem.imem_rdata;
              skid_pc4_reg <= addr_plus4;
              req_addr_reg <= addr_plus4;
            end
          end else if (taken) begin
            // Address must stay put until ack; remember where to go next.
            redirect_addr_reg <= target;
            valid_reg         <= 1'b0;
          end else if (consume) begin
            valid_reg <= 1'b0;
          end
        end
        S_WAIT: begin
          if (taken) begin
            req_addr_reg <= target;
            valid_reg    <= 1'b0;
          end else if (!stall) begin
            instr_reg <= skid_reg;
            pc4_reg   <= skid_pc4_reg;
            valid_reg <= 1'b1;
          end
        end
        S_DROP: begin
          valid_reg <= 1'b0;
          if (imem.imem_ack) req_addr_reg <= redirect_addr_reg;
        end
        default: valid_reg <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model with selectable latency, a
// small control-unit decode, and two monitors (fetch addresses, delivered
// instructions) checking against queues filled by the directed stimulus.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h00000000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } deliv_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        zero;
  logic        jump;
  logic        beq;
  logic        bne;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc_plus4;
  logic        instr_valid;

  int          lat;
  int          wait_cnt;
  int          n_checks;
  int          n_fail;
  int          pop_cnt;
  bit          mon_en;

  deliv_t      exp_q[$];
  logic [31:0] addr_q[$];

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (bus.master),
    .stall       (stall),
    .jump        (jump),
    .beq         (beq),
    .bne         (bne),
    .zero        (zero),
    .instr       (instr),
    .opcode      (opcode),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: every unlisted word is an addi tagged with its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00000000: return 32'h20080005; // addi
      32'h0000000C: return 32'h11090003; // beq +3 -> 0x1C
      32'h0000001C: return 32'h0BFFFFFE; // j -> 0x0FFFFFF8
      32'h10000000: return 32'h08000040; // j -> 0x10000100
      32'h10000100: return 32'h15090003; // bne, not taken with zero=1
      32'h10000120: return 32'h08000080; // j -> 0x10000200
      default:      return {16'h2000, a[15:0]};
    endcase
  endfunction

  // Memory: ack after 'lat' waiting cycles (0 = same-cycle ack).
  assign bus.imem_ack   = bus.imem_req && (wait_cnt >= lat);
  assign bus.imem_rdata = bus.imem_ack ? mem_word(bus.imem_addr) : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (reset || !bus.imem_req || bus.imem_ack) wait_cnt <= 0;
    else                                        wait_cnt <= wait_cnt + 1;
  end

  // Control-unit decode of the IF/ID opcode.
  assign jump = (opcode == 6'b000010);
  assign beq  = (opcode == 6'b000100);
  assign bne  = (opcode == 6'b000101);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h required %08h", name, act, req);
    end
  endtask

  task automatic push_seq(input logic [31:0] a);
    deliv_t d;
    d.instr = mem_word(a);
    d.pc4   = a + 32'd4;
    addr_q.push_back(a);
    exp_q.push_back(d);
  endtask

  task automatic push_wp(input logic [31:0] a);
    addr_q.push_back(a);
  endtask

  task automatic push_run(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) push_seq(a + 32'(4 * i));
  endtask

  task automatic wait_pops(input int n);
    int cyc;
    cyc = 0;
    while (pop_cnt < n && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("pop_count", pop_cnt, n);
  endtask

  // Delivery monitor: each instruction accepted by decode is popped and compared.
  initial begin : deliv_monitor
    deliv_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && instr_valid && !stall) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_instr: got %08h required none", instr);
        end else begin
          e = exp_q.pop_front();
          check("instr", instr, e.instr);
          check("pc_plus4", pc_plus4, e.pc4);
          check("opcode", {26'd0, opcode}, {26'd0, e.instr[31:26]});
          pop_cnt++;
          $display("deliver instr=%08h pc_plus4=%08h (expected %08h/%08h)",
                   instr, pc_plus4, e.instr, e.pc4);
        end
      end
    end
  end

  // Fetch monitor: accepted addresses in order, and address held while pending.
  initial begin : addr_monitor
    logic        pend_prev;
    logic [31:0] addr_prev;
    logic [31:0] exp_a;
    pend_prev = 1'b0;
    addr_prev = 32'd0;
    forever begin
      @(negedge clk);
      if (!mon_en || reset) begin
        pend_prev = 1'b0;
      end else begin
        if (pend_prev && bus.imem_req) check("addr_stable", bus.imem_addr, addr_prev);
        if (bus.imem_req && bus.imem_ack) begin
          if (addr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_fetch: got %08h required none", bus.imem_addr);
          end else begin
            exp_a = addr_q.pop_front();
            check("imem_addr", bus.imem_addr, exp_a);
          end
        end
        pend_prev = bus.imem_req && !bus.imem_ack;
        addr_prev = bus.imem_addr;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int base;
    n_checks = 0;
    n_fail   = 0;
    pop_cnt  = 0;
    mon_en   = 1'b0;
    reset    = 1'b1;
    stall    = 1'b0;
    zero     = 1'b1;
    lat      = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc4", pc_plus4, 32'd0);

    // Expected stream: beq taken, two jumps, a not-taken bne, a third jump.
    push_seq(32'h00); push_seq(32'h04); push_seq(32'h08); push_seq(32'h0C);
    push_wp(32'h10);
    push_seq(32'h1C);
    push_wp(32'h20);
    push_seq(32'h0FFFFFF8); push_seq(32'h0FFFFFFC); push_seq(32'h10000000);
    push_wp(32'h10000004);
    push_run(32'h10000100, 9);
    push_wp(32'h10000124);
    push_run(32'h10000200, 16);

    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("first_req", {31'd0, bus.imem_req}, 32'd1);
    check("first_addr", bus.imem_addr, RESET_PC);
    check("first_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    check("valid_cycle2", {31'd0, instr_valid}, 32'd1);

    // Stall 3 cycles with IF/ID holding the word from 0x10000108.
    wait_pops(10);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_instr", instr, 32'h20000108);
      check("stall_pc4", pc_plus4, 32'h1000010C);
      if (i > 0) check("stall_req", {31'd0, bus.imem_req}, 32'd0);
      @(posedge clk); #1;
    end
    stall = 1'b0;

    // Slow memory: the jump at 0x10000120 resolves while 0x10000124 is pending.
    wait_pops(14);
    lat = 2;
    wait_pops(19);
    lat = 0;
    repeat (2) begin @(posedge clk); #1; end

    // Enter S_WAIT, then reset from there.
    stall = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("wait_req", {31'd0, bus.imem_req}, 32'd0);
    @(posedge clk); #1;
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    check("rst_comb_req", {31'd0, bus.imem_req}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check("midrst_req", {31'd0, bus.imem_req}, 32'd0);
    check("midrst_instr", instr, 32'd0);
    check("midrst_pc4", pc_plus4, 32'd0);

    exp_q.delete();
    addr_q.delete();
    push_seq(32'h00); push_seq(32'h04); push_seq(32'h08); push_seq(32'h0C);
    push_wp(32'h10);
    push_seq(32'h1C);
    push_wp(32'h20);
    push_wp(32'h0FFFFFF8);
    exp_q.pop_back();
    exp_q.push_back('{instr: mem_word(32'h1C), pc4: 32'h20});
    base = pop_cnt;

    @(posedge clk); #1;
    stall  = 1'b0;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("restart_req", {31'd0, bus.imem_req}, 32'd1);
    check("restart_addr", bus.imem_addr, RESET_PC);
    wait_pops(base + 5);
    mon_en = 1'b0;
    check("drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the Antares-R2 pipeline. Produces the instruction word whose opcode feeds control_unit, and consumes control_unit's jump/beq/bne decisions to redirect the PC.
- Owns the PC, a req/ack handshake to instruction memory, the IF/ID instruction register, and a one-entry skid buffer.
- Wrong-path instructions are discarded on a taken branch or jump.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset; address of the first fetch.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address; stable while imem_req=1 until imem_ack
- imem_ack  input  1  instruction memory response valid; may assert in the same cycle as imem_req
- imem_rdata  input  32  instruction word, valid when imem_ack=1
- stall  input  1  decode cannot accept a new instruction; IF/ID register holds
- jump  input  1  from control_unit, qualifies the instruction in IF/ID
- beq  input  1  from control_unit
- bne  input  1  from control_unit
- zero  input  1  register-compare equality for the instruction in ID
- instr  output  32  IF/ID instruction register
- opcode  output  6  instr[31:26], drives control_unit opCode
- pc_plus4  output  32  IF/ID copy of (fetch address + 4)
- instr_valid  output  1  IF/ID register holds a valid instruction

Behaviour:
- Reset: pc=RESET_PC, instr=0, pc_plus4=0, instr_valid=0, skid empty, state=S_REQ, imem_req=0 while reset=1. First cycle after reset: imem_req=1, imem_addr=RESET_PC.
- consume = instr_valid & ~stall.
- taken = consume & (jump | (beq & zero) | (bne & ~zero)). jump has priority for target selection.
- Branch target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}.
- Jump target = {pc_plus4[31:28], instr[25:0], 2'b00}. All arithmetic is 32-bit modulo; wrap at 2^32 is legal and unflagged.
- Any taken redirect clears instr_valid on the same edge, flushing the wrong-path slot.
- imem_addr is the registered req_addr. imem_req=1 in S_REQ and S_DROP; imem_req=0 in S_WAIT.
- FSM S_REQ, imem_ack=1:
  - taken: discard rdata; req_addr<=target; stay S_REQ.
  - else if IF/ID free (~instr_valid | ~stall): instr<=rdata; pc_plus4<=req_addr+4; instr_valid<=1; req_addr<=req_addr+4; stay S_REQ.
  - else: skid<=rdata, skid_pc4<=req_addr+4; req_addr<=req_addr+4; go S_WAIT.
- FSM S_REQ, imem_ack=0:
  - taken: latch target into req_next; keep req_addr (protocol: address held until ack); go S_DROP.
  - else if consume: instr_valid<=0.
- FSM S_WAIT:
  - taken: discard skid; req_addr<=target; go S_REQ.
  - else if ~stall: IF/ID<=skid, instr_valid<=1; go S_REQ.
  - else: hold.
- FSM S_DROP: instr_valid=0, so no redirect is possible. On imem_ack: discard rdata; req_addr<=req_next; go S_REQ.
- Throughput: zero-wait memory with ~stall gives one instruction per cycle. Latency is req-to-instr_valid = ack cycle + 1 edge.
- Reset mid-operation: outstanding request and skid are abandoned. A late imem_ack arriving after reset is ignored only if the memory protocol also resets; both sides share the same reset.
- Flush of a delay slot is by design: no branch delay slot.

Test Plan:
- Reset then zero-wait ack returning 0x20080005 (addi) -> imem_addr 0,4,8 on consecutive cycles; instr_valid=1 from cycle 2; opcode=6'b001000; pc_plus4=4.
- IF/ID holds beq (0x1109_0003) with zero=1, stall=0, pc_plus4=0x10 -> next imem_addr=0x1C; instr_valid=0 for one cycle; wrong-path word at 0x10 never appears.
- IF/ID holds a jump with instr[25:0]=0x0000040 and pc_plus4=0x10000004 -> imem_addr=0x10000100. The same word with bne and zero=1 -> no redirect; sequential fetch continues.
- stall=1 held 3 cycles with zero-wait ack -> one word captured in skid; imem_req=0; instr and pc_plus4 unchanged. On stall=0 the skid word loads next edge with no lost or duplicated address.
- 2-cycle-latency memory with a taken jump while the request is outstanding -> imem_addr held until ack; returned data discarded; next request to the jump target.
- reset asserted while in S_WAIT -> next cycle instr_valid=0, imem_req=0. After release, fetch restarts at RESET_PC.
